pipeline_delay_line: RTL and testbench

- Parametrised data+valid delay line. Successor to the fixed single-bit valid delay.
- Carries a WIDTH-bit payload alongside valid and adds pipeline stall (en), synchronous flush, and run-time latency selection up to MAX_LATENCY.
- The latency change is safe: it is applied only once the line has drained.
- Sits between datapath stages that need a matched, reconfigurable delay, e.g. aligning side-band data with a variable-latency arithmetic path.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/pipeline_delay_stage.sv | 31 +++
 rtl/pipeline_delay_line.sv | 94 +++++++++
 tb/tb_pipeline_delay_line.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared stage type, latency clamp and latency-change FSM states for pipeline_delay_line
// Contents: PIPELINE_STAGE_T(W) macro (packed {valid, data[W-1:0]}, valid in the MSB),
//           lat_state_e, clamp_latency(req, max_lat).
`ifndef PIPELINE_PKG_SV
`define PIPELINE_PKG_SV
`define PIPELINE_STAGE_T(W) struct packed {logic valid; logic [(W)-1:0] data;}

package pipeline_pkg;

    typedef enum logic {
        LAT_IDLE    = 1'b0,
        LAT_PENDING = 1'b1
    } lat_state_e;

    function automatic int unsigned clamp_latency(input int unsigned req, input int unsigned max_lat);
        return (req > max_lat) ? max_lat : req;
    endfunction

endpackage

`endif

// File: rtl/pipeline_delay_stage.sv
// pipeline_delay_stage: one {valid, data} register of the delay line
// Ports: clk, rst_n (async, clears valid only), en (advance), clear (sync valid clear, beats en),
//        d / q = {valid, data[WIDTH-1:0]}.
module pipeline_delay_stage #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           clear,
    input  logic [WIDTH:0] d,
    output logic [WIDTH:0] q
);

    logic             vld;
    logic [WIDTH-1:0] dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     vld <= 1'b0;
        else if (clear) vld <= 1'b0;
        else if (en)    vld <= d[WIDTH];
    end

    // Payload is qualified by vld, so it needs no reset.
    always_ff @(posedge clk) begin
        if (en) dat <= d[WIDTH-1:0];
    end

    assign q = {vld, dat};

endmodule

// File: rtl/pipeline_delay_line.sv
// pipeline_delay_line: data+valid delay line with stall, flush and drain-safe run-time latency change
// Ports: clk, rst_n (async active-low), en (advance), flush (sync clear),
//        in_valid/in_data/in_ready (input side), o_valid/o_data (output tap),
//        cfg_load/cfg_latency (request new latency), active_latency, in_flight (status).
module pipeline_delay_line
    import pipeline_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MAX_LATENCY = 20,
    parameter int LATENCY     = 4,
    parameter int CNT_W       = $clog2(MAX_LATENCY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_latency,
    output logic [CNT_W-1:0] active_latency,
    output logic [CNT_W-1:0] in_flight
);

    typedef `PIPELINE_STAGE_T(WIDTH) stage_t;

    localparam logic [CNT_W-1:0] RST_LAT = CNT_W'(clamp_latency(LATENCY, MAX_LATENCY));

    stage_t           chain [MAX_LATENCY+1];
    stage_t           tap;
    lat_state_e       state;
    logic [CNT_W-1:0] pend_lat;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] tap_idx;
    logic             adv;
    logic             acc;
    logic             lat_nz;
    logic             apply;

    assign adv      = en & ~flush;
    assign in_ready = state == LAT_IDLE;
    assign acc      = in_valid & in_ready & adv;
    assign lat_nz   = active_latency != '0;
    assign chain[0] = {acc, in_data};

    genvar i;
    for (i = 0; i < MAX_LATENCY; i++) begin : g_stage
        pipeline_delay_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .clear (flush | apply),
            .d     (chain[i]),
            .q     (chain[i+1])
        );
    end

    // Tap stage L-1 (chain[L]); L=0 bypasses the registers entirely.
    assign tap_idx = active_latency - CNT_W'(lat_nz);

    always_comb begin
        tap = chain[1];
        for (int k = 1; k < MAX_LATENCY; k++)
            if (tap_idx == CNT_W'(k)) tap = chain[k+1];
    end

    assign o_valid = lat_nz ? tap.valid & adv : acc;
    assign o_data  = lat_nz ? tap.data : in_data;

    assign cnt_nxt   = flush ? '0 : cnt + CNT_W'(acc & lat_nz) - CNT_W'(o_valid & lat_nz);
    assign in_flight = cnt;

    // A fresh cfg_load keeps the line pending, so the newest request always wins.
    assign apply = (state == LAT_PENDING) & ~cfg_load & (cnt_nxt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= LAT_IDLE;
            pend_lat       <= '0;
            active_latency <= RST_LAT;
            cnt            <= '0;
        end else begin
            cnt   <= cnt_nxt;
            state <= cfg_load ? LAT_PENDING : apply ? LAT_IDLE : state;
            if (cfg_load) pend_lat <= CNT_W'(clamp_latency(32'(cfg_latency), MAX_LATENCY));
            if (apply) active_latency <= pend_lat;
        end
    end

endmodule

// File: tb/tb_pipeline_delay_line.sv
// tb_pipeline_delay_line: directed literal checks plus randomized run against a queue-based reference model
module tb_pipeline_delay_line;

    localparam int WIDTH = 32;
    localparam int MAXL  = 20;
    localparam int LAT   = 4;
    localparam int CNT_W = $clog2(MAXL + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             cfg_load = 1'b0;
    logic [CNT_W-1:0] cfg_latency = '0;
    logic             in_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic [CNT_W-1:0] active_latency;
    logic [CNT_W-1:0] in_flight;

    pipeline_delay_line #(.WIDTH(WIDTH), .MAX_LATENCY(MAXL), .LATENCY(LAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .o_valid        (o_valid),
        .o_data         (o_data),
        .cfg_load       (cfg_load),
        .cfg_latency    (cfg_latency),
        .active_latency (active_latency),
        .in_flight      (in_flight)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each accepted entry is due on advance-cycle index (accept index + L).
    typedef struct {
        logic [WIDTH-1:0] data;
        longint           due;
    } ent_t;

    ent_t   q[$];
    longint adv_idx;
    int     m_lat;
    bit     m_pend;
    int     m_pl;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            adv_idx = 0;
            m_lat   = LAT;
            m_pend  = 1'b0;
            m_pl    = 0;
        end else begin
            bit adv_now;
            bit acc;
            adv_now = en && !flush;
            acc     = in_valid && !m_pend && adv_now;
            if (flush) q.delete();
            else begin
                if (adv_now && q.size() > 0 && q[0].due == adv_idx) void'(q.pop_front());
                if (acc && m_lat > 0) q.push_back('{in_data, adv_idx + m_lat});
            end
            if (adv_now) adv_idx++;
            if (cfg_load) begin
                m_pend = 1'b1;
                m_pl   = (int'(cfg_latency) > MAXL) ? MAXL : int'(cfg_latency);
            end else if (m_pend && q.size() == 0) begin
                m_lat  = m_pl;
                m_pend = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            bit               exp_v;
            logic [WIDTH-1:0] exp_d;
            if (m_lat == 0) begin
                exp_v = in_valid && !m_pend && en && !flush;
                exp_d = in_data;
            end else begin
                exp_v = en && !flush && q.size() > 0 && q[0].due == adv_idx;
                exp_d = (q.size() > 0) ? q[0].data : '0;
            end
            check("m_o_valid", 64'(o_valid), 64'(exp_v));
            if (exp_v) check("m_o_data", 64'(o_data), 64'(exp_d));
            check("m_in_flight", 64'(in_flight), 64'(q.size()));
            check("m_in_ready", 64'(in_ready), 64'(!m_pend));
            check("m_active_latency", 64'(active_latency), 64'(m_lat));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_latency(input int lat);
        cyc();
        in_valid    = 1'b0;
        en          = 1'b1;
        cfg_load    = 1'b1;
        cfg_latency = CNT_W'(lat);
        cyc();
        cfg_load = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_in_flight", 64'(in_flight), 64'd0);
        check("rst_active_latency", 64'(active_latency), 64'd4);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Ten back-to-back entries at L=4.
        for (int k = 0; k < 14; k++) begin
            cyc();
            en       = 1'b1;
            in_valid = k < 10;
            in_data  = 32'h10 + 32'(k);
            @(negedge clk);
            if (k >= 4) check("t1_out", 64'({o_valid, o_data}), 64'({1'b1, 32'h10 + 32'(k - 4)}));
            if (k <= 10) check("t1_in_flight", 64'(in_flight), 64'((k < 4) ? k : 4));
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            in_valid = 1'b0;
        end

        // Stall: 0xAA at cycle 0, en low on cycles 2..4, out at cycle 7.
        for (int k = 0; k < 8; k++) begin
            cyc();
            en       = !(k >= 2 && k <= 4);
            in_valid = k == 0;
            in_data  = 32'hAA;
            @(negedge clk);
            if (k >= 2 && k <= 4) begin
                check("t2_stall_o_valid", 64'(o_valid), 64'd0);
                check("t2_stall_in_flight", 64'(in_flight), 64'd1);
            end
            if (k == 7) check("t2_out", 64'({o_valid, o_data}), 64'({1'b1, 32'hAA}));
        end

        // Out-of-range request clamps; empty line applies two edges after the pulse.
        set_latency(31);
        @(negedge clk);
        check("t3_pending_in_ready", 64'(in_ready), 64'd0);
        cyc();
        @(negedge clk);
        check("t3_clamped_latency", 64'(active_latency), 64'd20);
        check("t3_in_ready", 64'(in_ready), 64'd1);

        // Latency 0: combinational bypass gated by en.
        set_latency(0);
        cyc();
        in_valid = 1'b1;
        in_data  = 32'h55;
        en       = 1'b1;
        @(negedge clk);
        check("t4_active_latency", 64'(active_latency), 64'd0);
        check("t4_bypass", 64'({o_valid, o_data}), 64'({1'b1, 32'h55}));
        check("t4_in_flight", 64'(in_flight), 64'd0);
        cyc();
        en = 1'b0;
        @(negedge clk);
        check("t4_bypass_stall", 64'(o_valid), 64'd0);
        set_latency(3);
        cyc();

        // Randomized traffic, flushes, reconfigurations and one async reset.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            en          = $urandom_range(0, 9) < 8;
            in_valid    = $urandom_range(0, 9) < 6;
            in_data     = $urandom;
            flush       = $urandom_range(0, 99) < 3;
            cfg_load    = $urandom_range(0, 99) < 2;
            cfg_latency = CNT_W'($urandom_range(0, 24));
            if (n == 1500) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("t5_rst_o_valid", 64'(o_valid), 64'd0);
                check("t5_rst_in_flight", 64'(in_flight), 64'd0);
                check("t5_rst_active_latency", 64'(active_latency), 64'd4);
                cyc();
                #2;
                rst_n = 1'b1;
            end
        end
        cyc();
        flush    = 1'b0;
        cfg_load = 1'b0;
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
